// File: rtl/mem_access_pkg.sv
// Shared op encodings, FSM state type and store-lane helpers for the pipeline MEM stage.
package mem_access_pkg;

    localparam int unsigned ALU_OP_BUS = 8;
    typedef logic [ALU_OP_BUS-1:0] alu_op_t;

    localparam alu_op_t EXE_NOP_OP = 8'h00;
    localparam alu_op_t EXE_ADD_OP = 8'h01;
    localparam alu_op_t EXE_LB_OP  = 8'h20;
    localparam alu_op_t EXE_LH_OP  = 8'h21;
    localparam alu_op_t EXE_LW_OP  = 8'h23;
    localparam alu_op_t EXE_LBU_OP = 8'h24;
    localparam alu_op_t EXE_LHU_OP = 8'h25;
    localparam alu_op_t EXE_SB_OP  = 8'h28;
    localparam alu_op_t EXE_SH_OP  = 8'h29;
    localparam alu_op_t EXE_SW_OP  = 8'h2b;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mem_state_e;

    function automatic logic is_load_op(input alu_op_t op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store_op(input alu_op_t op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic [3:0] store_be(input alu_op_t op, input logic [1:0] lane);
        logic [3:0] be;
        case (op)
            EXE_SB_OP: be = 4'b0001 << lane;
            EXE_SH_OP: be = lane[1] ? 4'b1100 : 4'b0011;
            EXE_SW_OP: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input alu_op_t op, input logic [31:0] sdata);
        logic [31:0] wd;
        case (op)
            EXE_SB_OP: wd = {4{sdata[7:0]}};
            EXE_SH_OP: wd = {2{sdata[15:0]}};
            default:   wd = sdata;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Combinational load-result extraction: picks the byte/half lane and sign- or zero-extends it.
module load_align
    import mem_access_pkg::*;
(
    input  alu_op_t     op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*addr +: 8];
        half_sel = addr[1] ? word[31:16] : word[15:0];
        case (op)
            EXE_LB_OP:  data = {{24{byte_sel[7]}}, byte_sel};
            EXE_LBU_OP: data = {24'h0, byte_sel};
            EXE_LH_OP:  data = {{16{half_sel[15]}}, half_sel};
            EXE_LHU_OP: data = {16'h0, half_sel};
            default:    data = word;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: req/ack data-memory transaction with stall and write-back muxing.
// Optional MEM_ALIGN_CHECK_EN adds misaligned-access detection and the addr_err port.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  alu_op_t     mem_alu_op,
    input  logic [31:0] mem_sdata,
    input  logic [31:0] mem_lsaddr,
    input  logic [31:0] mem_wdata,
    input  logic [4:0]  mem_waddr,
    input  logic        mem_wen,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic        mem_wen_hilo,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall_req,
    output logic [31:0] wb_wdata,
    output logic [4:0]  wb_waddr,
    output logic        wb_wen,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_wen_hilo,
    output logic        bus_err
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        addr_err
`endif
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

    mem_state_e  state_q, state_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        addr_err_q, addr_err_d;

    logic        is_load, is_store, is_mem, misaligned;
    logic [31:0] load_data;

    assign is_load  = is_load_op(mem_alu_op);
    assign is_store = is_store_op(mem_alu_op);
    assign is_mem   = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        case (mem_alu_op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misaligned = mem_lsaddr[0];
            EXE_LW_OP, EXE_SW_OP:             misaligned = |mem_lsaddr[1:0];
            default:                          misaligned = 1'b0;
        endcase
    end
    assign addr_err = addr_err_q;
`else
    assign misaligned = 1'b0;
`endif

    load_align u_load_align (
        .op   (mem_alu_op),
        .addr (mem_lsaddr[1:0]),
        .word (rdata_q),
        .data (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_be_q    <= '0;
            dm_wdata_q <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            bus_err_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_be_q    <= dm_be_d;
            dm_wdata_q <= dm_wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            bus_err_q  <= bus_err_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_be_d    = dm_be_q;
        dm_wdata_d = dm_wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        bus_err_d  = 1'b0;
        addr_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_mem) begin
                    if (misaligned) begin
                        addr_err_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        dm_req_d   = 1'b1;
                        dm_we_d    = is_store;
                        dm_addr_d  = {mem_lsaddr[31:2], 2'b00};
                        dm_be_d    = is_store ? store_be(mem_alu_op, mem_lsaddr[1:0]) : 4'b1111;
                        dm_wdata_d = store_wdata(mem_alu_op, mem_sdata);
                        cnt_d      = '0;
                        state_d    = StBusy;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q + CntW'(1);
                // ACK takes priority over a coincident timeout.
                if (dm_ack) begin
                    dm_req_d = 1'b0;
                    if (is_load) rdata_d = dm_rdata;
                    state_d  = StDone;
                end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                    dm_req_d  = 1'b0;
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign stall_req = ((state_q == StIdle) && is_mem) || (state_q == StBusy);

    always_comb begin
        wb_wdata    = mem_wdata;
        wb_waddr    = mem_waddr;
        wb_wen      = mem_wen;
        wb_hi       = mem_hi;
        wb_lo       = mem_lo;
        wb_wen_hilo = mem_wen_hilo;
        if (state_q == StDone) begin
            if (is_load) wb_wdata = load_data;
            if (is_store || bus_err_q || addr_err_q) wb_wen = 1'b0;
            if (bus_err_q) wb_wen_hilo = 1'b0;
        end
        if (stall_req) begin
            wb_wen      = 1'b0;
            wb_wen_hilo = 1'b0;
        end
    end

    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_be    = dm_be_q;
    assign dm_wdata = dm_wdata_q;
    assign bus_err  = bus_err_q;

endmodule
